// File: rtl/vram_port.sv
// vram_port: single-port VRAM arbiter between CPU load/store and display scanout,
// display-first with a starvation bound on pending CPU requests.
module vram_port #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_active,
  input  logic              cpu_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t state, state_n;
  logic [7:0] starve_cnt, starve_n;
  logic eligible, cpu_gnt;
  always_comb begin
    eligible = state == S_IDLE && cpu_active;
    cpu_gnt  = !rst && eligible && (!disp_req || starve_cnt == 8'(STARVE_MAX));
    disp_gnt = !rst && disp_req && !cpu_gnt;
    state_n  = cpu_gnt ? S_ACK : S_IDLE;
    starve_n = (cpu_gnt || !eligible) ? 8'd0 :
               (disp_gnt && starve_cnt != 8'(STARVE_MAX)) ? starve_cnt + 8'd1 : starve_cnt;
    mem_addr = cpu_gnt ? cpu_addr : disp_gnt ? disp_addr : '0;
    mem_we   = cpu_gnt && cpu_w;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= 8'd0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      disp_valid <= disp_gnt;
    end
  end
  assign cpu_ready  = state == S_ACK;
  assign cpu_rdata  = mem_rdata;
  assign disp_rdata = mem_rdata;
  assign mem_wdata  = cpu_wdata;
endmodule
